// File: rtl/mem_resp_pkg.sv
// Shared constants for the memory responder: FSM encoding and limits.
package mem_resp_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MAX_READ_LAT = 4;
    localparam int CNT_W        = 32;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM, one read/write port, registered read.
module mem_resp_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: zero-fill FSM, fixed-latency reads, sticky errors.
// Optional read/write counters are built when MEM_RESP_STATS_EN is defined.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DEPTH_AW = 10,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    output logic              init_busy,
    output logic              err_oor,
    output logic              err_busy,
    input  logic              err_clr
`ifdef MEM_RESP_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
`endif
);

    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
        $error("READ_LAT out of range");
    end

    logic [0:0]          state;
    logic [DEPTH_AW-1:0] ptr;
    logic                in_init;
    logic                in_range;
    logic                rd_fire;
    logic                wr_fire;
    logic                oor_q;
    logic [READ_LAT-1:0] vld_pipe;
    logic [MEM_DW-1:0]   hold;
    logic [MEM_DW-1:0]   s0;
    logic [MEM_DW-1:0]   data_out;

    logic                ram_en;
    logic                ram_we;
    logic [DEPTH_AW-1:0] ram_addr;
    logic [MEM_DW-1:0]   ram_wdata;
    logic [MEM_DW-1:0]   ram_q;

    assign in_init   = (state == ST_INIT);
    assign init_busy = in_init;
    assign in_range  = (mem_addr >> DEPTH_AW) == '0;
    assign rd_fire   = !in_init && mem_req && !mem_write;
    assign wr_fire   = !in_init && mem_req && mem_write;

    // The init FSM owns the RAM port; requests during fill never reach it.
    assign ram_en    = in_init || (mem_req && in_range);
    assign ram_we    = in_init || mem_write;
    assign ram_addr  = in_init ? ptr : mem_addr[DEPTH_AW-1:0];
    assign ram_wdata = in_init ? '0 : mem_wdata;

    mem_resp_ram #(
        .AW (DEPTH_AW),
        .DW (MEM_DW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else if (in_init) begin
            ptr <= ptr + 1'b1;
            if (ptr == {DEPTH_AW{1'b1}}) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            oor_q    <= 1'b0;
        end else begin
            vld_pipe[0] <= rd_fire;
            for (int k = 1; k < READ_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            oor_q <= rd_fire && !in_range;
        end
    end

    // Stage 0 data is the RAM's own output register, masked for OOR reads.
    assign s0 = oor_q ? '0 : ram_q;

    if (READ_LAT == 1) begin : g_lat1
        assign data_out = s0;
    end else begin : g_latn
        logic [MEM_DW-1:0] dpipe [READ_LAT-1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < READ_LAT-1; k++) begin
                    dpipe[k] <= '0;
                end
            end else begin
                dpipe[0] <= s0;
                for (int k = 1; k < READ_LAT-1; k++) begin
                    dpipe[k] <= dpipe[k-1];
                end
            end
        end
        assign data_out = dpipe[READ_LAT-2];
    end

    assign mem_rdata_vld = vld_pipe[READ_LAT-1];
    assign mem_rdata     = mem_rdata_vld ? data_out : hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (mem_rdata_vld) begin
            hold <= data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_oor  <= 1'b0;
            err_busy <= 1'b0;
        end else begin
            if (!in_init && mem_req && !in_range) begin
                err_oor <= 1'b1;
            end else if (err_clr) begin
                err_oor <= 1'b0;
            end
            if (in_init && mem_req) begin
                err_busy <= 1'b1;
            end else if (err_clr) begin
                err_busy <= 1'b0;
            end
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (stats_clr) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_fire && rd_count != {CNT_W{1'b1}}) begin
                rd_count <= rd_count + 1'b1;
            end
            if (wr_fire && wr_count != {CNT_W{1'b1}}) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end
`endif

endmodule
